mbc_ram_arbiter: RTL and testbench

Clocked arbiter that shares the cartridge save SRAM between the Game Boy bus and a host-side save-backup port. Sits between the MBC1 banking logic, which supplies the asynchronous GB RAM chip-select, and the top-level SRAM pin mux. The GB always has absolute priority. Host reads and writes run only in GB idle windows and are aborted cleanly if the GB claims the RAM mid-cycle.

---
 rtl/mbc_ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mbc_ram_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbc_ram_arbiter.sv
`timescale 1ns/1ps
// mbc_ram_arbiter
// Shares the cartridge save SRAM between the Game Boy bus and a host-side
// save-backup port. The GB always wins: host accesses start only after the
// GB has been idle for GUARD_CYCLES synchronised clocks. If the GB selects
// the RAM mid-access, the host access is dropped at once and retried later.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   gb_ram_cs             GB RAM select from MBC1 (asynchronous to clk)
//   host_req/host_we      level request held until host_ack; 1 = write
//   host_addr/host_wdata  SRAM byte address / write data
//   host_ack              one-cycle completion pulse
//   host_rdata            read data, valid from host_ack until next read
//   ram_owner_gb          1 = SRAM pins routed to the GB bus
//   ram_addr/ram_dq_out   host-side address / write data to the pin mux
//   ram_dq_oe             host-side data driver enable
//   ram_dq_in             SRAM data bus readback
//   ram_ce_n/we_n/oe_n    host-side SRAM strobes, active-low
//   abort_cnt             saturating abort counter
//
// Optional build macro: MBC_ARB_STATS_EN enables abort_cnt; without it
// abort_cnt reads as 8'h00.
module mbc_ram_arbiter #(
  parameter int STROBE_CYCLES = 3,
  parameter int GUARD_CYCLES  = 4,
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gb_ram_cs,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_owner_gb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_in,
  output logic              ram_ce_n,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic [7:0]        abort_cnt
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD_CYCLES);
  localparam logic [SW-1:0] STROBE_END = SW'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  function automatic logic [GW-1:0] guard_sat_inc(input logic [GW-1:0] v);
    return (v == GUARD_MAX) ? v : v + GW'(1);
  endfunction

  state_t          state, state_nxt;
  logic            gb_cs_p0, gb_cs_p1;
  logic            gb_busy;
  logic [GW-1:0]   guard;
  logic [SW-1:0]   str_cnt;
  logic            we_q;
  logic            access;
  logic            abort;
  logic            start;

  // ---- stage p0/p1: two-flop synchroniser for the GB chip-select ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gb_cs_p0 <= 1'b0;
      gb_cs_p1 <= 1'b0;
    end else begin
      gb_cs_p0 <= gb_ram_cs;
      gb_cs_p1 <= gb_cs_p0;
    end
  end

  assign gb_busy = gb_cs_p1;

  // ---- guard counter: consecutive idle clocks, saturating ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       guard <= '0;
    else if (gb_busy) guard <= '0;
    else              guard <= guard_sat_inc(guard);
  end

  assign access = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign abort  = access && gb_busy;

  // ---- access FSM: next state ----
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        // gb_busy is checked here too so a guard that saturates in the same
        // clock the GB returns cannot start an access.
        if (host_req && (guard == GUARD_MAX) && !gb_busy) begin
          start     = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP:  state_nxt = gb_busy ? S_IDLE : S_STROBE;
      S_STROBE: begin
        if (gb_busy)                   state_nxt = S_IDLE;
        else if (str_cnt == STROBE_END) state_nxt = S_HOLD;
      end
      S_HOLD:   state_nxt = gb_busy ? S_IDLE : S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---- access FSM: state, strobe timer, request latch, read capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      str_cnt    <= '0;
      we_q       <= 1'b0;
      ram_addr   <= '0;
      ram_dq_out <= '0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_STROBE) str_cnt <= str_cnt + SW'(1);
      else                   str_cnt <= '0;
      if (start) begin
        we_q       <= host_we;
        ram_addr   <= host_addr;
        ram_dq_out <= host_wdata;
      end
      // An abort in the final strobe clock must leave host_rdata untouched.
      if ((state == S_STROBE) && (str_cnt == STROBE_END) && !we_q && !gb_busy)
        host_rdata <= ram_dq_in;
    end
  end

  // Outputs decode straight from state so that reset and abort release the
  // SRAM pins without any extra register delay.
  assign ram_owner_gb = !access;
  assign ram_ce_n     = !access;
  assign ram_we_n     = !((state == S_STROBE) && we_q);
  assign ram_oe_n     = !((state == S_STROBE) && !we_q);
  assign ram_dq_oe    = access && we_q;
  assign host_ack     = (state == S_DONE);

`ifdef MBC_ARB_STATS_EN
  function automatic logic [7:0] abort_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] abort_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     abort_q <= '0;
    else if (abort) abort_q <= abort_sat_inc(abort_q);
  end

  assign abort_cnt = abort_q;
`else
  assign abort_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_mbc_ram_arbiter.sv
`timescale 1ns/1ps
module tb_mbc_ram_arbiter;

  localparam int STROBE = 3;
  localparam int GUARD  = 4;
  localparam int SYNC   = 2;
  localparam int LAT    = 1 + STROBE + 1 + 1;
  localparam int TMO    = 200;

  logic        clk;
  logic        rst_n;
  logic        gb_ram_cs;
  logic        host_req;
  logic        host_we;
  logic [14:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        ram_owner_gb;
  logic [14:0] ram_addr;
  logic [7:0]  ram_dq_out;
  logic        ram_dq_oe;
  logic [7:0]  ram_dq_in;
  logic        ram_ce_n;
  logic        ram_we_n;
  logic        ram_oe_n;
  logic [7:0]  abort_cnt;

  mbc_ram_arbiter #(.STROBE_CYCLES(STROBE), .GUARD_CYCLES(GUARD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gb_ram_cs    (gb_ram_cs),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .ram_owner_gb (ram_owner_gb),
    .ram_addr     (ram_addr),
    .ram_dq_out   (ram_dq_out),
    .ram_dq_oe    (ram_dq_oe),
    .ram_dq_in    (ram_dq_in),
    .ram_ce_n     (ram_ce_n),
    .ram_we_n     (ram_we_n),
    .ram_oe_n     (ram_oe_n),
    .abort_cnt    (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM behavioural model and bus monitor, sampled mid-cycle.
  logic [7:0] sram [0:32767];
  int n_we, n_oe, n_dqoe, n_ce, n_ack, n_conflict;

  initial begin
    n_we = 0; n_oe = 0; n_dqoe = 0; n_ce = 0; n_ack = 0; n_conflict = 0;
  end

  assign ram_dq_in = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr] : 8'hEE;

  always @(negedge clk) begin
    if (!ram_we_n)  n_we   <= n_we + 1;
    if (!ram_oe_n)  n_oe   <= n_oe + 1;
    if (ram_dq_oe)  n_dqoe <= n_dqoe + 1;
    if (!ram_ce_n)  n_ce   <= n_ce + 1;
    if (host_ack)   n_ack  <= n_ack + 1;
    if (((!ram_ce_n || !ram_we_n || !ram_oe_n || ram_dq_oe) && ram_owner_gb) ||
        (!ram_we_n && !ram_oe_n) || (ram_dq_oe && !ram_oe_n))
      n_conflict <= n_conflict + 1;
    if (!ram_ce_n && !ram_we_n) sram[ram_addr] <= ram_dq_out;
  end

  // Reference model state
  logic [7:0]  exp_mem [logic [14:0]];
  logic [14:0] pool [4];
  int          exp_aborts;
  int          n_pass, n_total;

  function automatic logic [7:0] exp_abort_cnt();
`ifdef MBC_ARB_STATS_EN
    return (exp_aborts > 255) ? 8'hFF : 8'(exp_aborts);
`else
    return 8'h00;
`endif
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one host access from the current time (just after an edge).
  task automatic do_access(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                           output int lat, output logic [7:0] rd, output bit ok);
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    lat = 0; ok = 1'b0; rd = 8'h00;
    while (!ok && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
      if (host_ack) begin
        ok = 1'b1;
        rd = host_rdata;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset;
    logic [44:0] got;
    rst_n = 1'b0; gb_ram_cs = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    exp_aborts = 0;
    wait_cycles(3);
    got = {ram_owner_gb, ram_ce_n, ram_we_n, ram_oe_n, ram_dq_oe, host_ack,
           host_rdata, ram_addr, ram_dq_out, abort_cnt};
    n_total++;
    if (got !== {6'b111100, 39'd0})
      $display("FAIL reset_values: got %h want %h", got, {6'b111100, 39'd0});
    else n_pass++;
    rst_n = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_write;
    int lat, s_we, s_dq, s_ack; logic [7:0] rd; bit ok;
    s_we = n_we; s_dq = n_dqoe; s_ack = n_ack;
    do_access(1'b1, 15'h1234, 8'h5A, lat, rd, ok);
    n_total++;
    if (!ok) $display("FAIL write_ack: no ack within %0d clocks", TMO); else n_pass++;
    exp_mem[15'h1234] = 8'h5A;
    n_total++;
    if (lat !== LAT) $display("FAIL write_latency: got %0d want %0d", lat, LAT); else n_pass++;
    wait_cycles(1);
    n_total++;
    if (host_ack !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", host_ack); else n_pass++;
    wait_cycles(1);
    n_total++;
    if (n_we - s_we !== STROBE)
      $display("FAIL write_we_len: got %0d want %0d", n_we - s_we, STROBE);
    else n_pass++;
    n_total++;
    if (n_dqoe - s_dq !== STROBE + 2)
      $display("FAIL write_dqoe_len: got %0d want %0d", n_dqoe - s_dq, STROBE + 2);
    else n_pass++;
    n_total++;
    if (n_ack - s_ack !== 1) $display("FAIL write_ack_count: got %0d want 1", n_ack - s_ack);
    else n_pass++;
    n_total++;
    if (sram[15'h1234] !== 8'h5A) $display("FAIL write_sram: got %h want 5a", sram[15'h1234]);
    else n_pass++;
  endtask

  task automatic test_read;
    int lat, s_oe, s_dq; logic [7:0] rd; bit ok;
    s_oe = n_oe; s_dq = n_dqoe;
    do_access(1'b0, 15'h1234, 8'hC3, lat, rd, ok);
    n_total++;
    if (!ok || rd !== 8'h5A) $display("FAIL read_data: got %h ok %0d want 5a", rd, ok);
    else n_pass++;
    n_total++;
    if (lat !== LAT) $display("FAIL read_latency: got %0d want %0d", lat, LAT); else n_pass++;
    wait_cycles(2);
    n_total++;
    if (n_oe - s_oe !== STROBE) $display("FAIL read_oe_len: got %0d want %0d", n_oe - s_oe, STROBE);
    else n_pass++;
    n_total++;
    if (n_dqoe - s_dq !== 0) $display("FAIL read_dqoe: got %0d want 0", n_dqoe - s_dq);
    else n_pass++;
    n_total++;
    if (host_rdata !== 8'h5A) $display("FAIL read_hold: got %h want 5a", host_rdata); else n_pass++;
  endtask

  task automatic test_guard;
    int k, s_ce; logic [14:0] a; logic [7:0] d;
    a = {2'b01, 13'($urandom)}; d = 8'($urandom_range(0, 255));
    gb_ram_cs = 1'b1;
    wait_cycles(3);
    host_we = 1'b1; host_addr = a; host_wdata = d; host_req = 1'b1;
    wait_cycles(2);
    // Idle window exactly GUARD clocks long: guard saturates as the GB returns.
    s_ce = n_ce;
    gb_ram_cs = 1'b0;
    wait_cycles(GUARD);
    gb_ram_cs = 1'b1;
    wait_cycles(6);
    n_total++;
    if (n_ce - s_ce !== 0 || ram_ce_n !== 1'b1)
      $display("FAIL guard_boundary: ce_n low %0d clocks want 0", n_ce - s_ce);
    else n_pass++;
    gb_ram_cs = 1'b0;
    k = 0;
    while (ram_ce_n && k < 50) begin @(posedge clk); #1; k++; end
    n_total++;
    if (k !== SYNC + GUARD + 1)
      $display("FAIL guard_delay: setup after %0d clocks want %0d", k, SYNC + GUARD + 1);
    else n_pass++;
    k = 0;
    while (!host_ack && k < TMO) begin @(posedge clk); #1; k++; end
    host_req = 1'b0;
    exp_mem[a] = d;
    wait_cycles(2);
    n_total++;
    if (k >= TMO || sram[a] !== d) $display("FAIL guard_write: got %h want %h", sram[a], d);
    else n_pass++;
  endtask

  task automatic test_abort;
    int k, s_ack; logic [14:0] a; logic [7:0] d;
    a = {2'b10, 13'($urandom)}; d = 8'($urandom_range(1, 255));
    wait_cycles(8);
    s_ack = n_ack;
    host_we = 1'b1; host_addr = a; host_wdata = d; host_req = 1'b1;
    k = 0;
    while (ram_we_n && k < 50) begin @(posedge clk); #1; k++; end
    n_total++;
    if (k !== 2) $display("FAIL abort_strobe_start: we_n low after %0d clocks want 2", k);
    else n_pass++;
    @(posedge clk); #1;
    gb_ram_cs = 1'b1;
    k = 0;
    while (!ram_owner_gb && k < 10) begin @(posedge clk); #1; k++; end
    n_total++;
    if (k > SYNC + 1 || ram_owner_gb !== 1'b1)
      $display("FAIL abort_release: owner_gb after %0d clocks want <= %0d", k, SYNC + 1);
    else n_pass++;
    exp_aborts++;
    wait_cycles(5);
    n_total++;
    if (n_ack - s_ack !== 0) $display("FAIL abort_no_ack: got %0d acks want 0", n_ack - s_ack);
    else n_pass++;
    n_total++;
    if (abort_cnt !== exp_abort_cnt())
      $display("FAIL abort_cnt: got %0d want %0d", abort_cnt, exp_abort_cnt());
    else n_pass++;
    gb_ram_cs = 1'b0;
    k = 0;
    while (!host_ack && k < TMO) begin @(posedge clk); #1; k++; end
    host_req = 1'b0;
    exp_mem[a] = d;
    wait_cycles(2);
    n_total++;
    if (k >= TMO || n_ack - s_ack !== 1)
      $display("FAIL abort_retry_ack: got %0d acks want 1", n_ack - s_ack);
    else n_pass++;
    n_total++;
    if (sram[a] !== d) $display("FAIL abort_retry_data: got %h want %h", sram[a], d); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, s_ack; logic [7:0] rd, d; bit ok1, ok2; logic [14:0] a;
    a = {2'b11, 13'($urandom)}; d = 8'($urandom_range(0, 255));
    wait_cycles(8);
    s_ack = n_ack;
    do_access(1'b1, a, d, lat1, rd, ok1);
    exp_mem[a] = d;
    wait_cycles(1);
    do_access(1'b0, a, 8'h00, lat2, rd, ok2);
    wait_cycles(4);
    n_total++;
    if (n_ack - s_ack !== 2 || !ok1 || !ok2)
      $display("FAIL b2b_acks: got %0d acks want 2", n_ack - s_ack);
    else n_pass++;
    n_total++;
    if (lat2 !== LAT) $display("FAIL b2b_latency: got %0d want %0d", lat2, LAT); else n_pass++;
    n_total++;
    if (rd !== d) $display("FAIL b2b_read: got %h want %h", rd, d); else n_pass++;
  endtask

  task automatic test_random;
    int lat; logic [7:0] rd, d; bit ok; logic we; int idx;
    for (int i = 0; i < 4; i++) begin
      pool[i] = {2'(i), 13'($urandom)};
      d = 8'($urandom_range(0, 255));
      do_access(1'b1, pool[i], d, lat, rd, ok);
      exp_mem[pool[i]] = d;
      n_total++;
      if (!ok) $display("FAIL rand_init_ack: bank %0d no ack", i); else n_pass++;
      wait_cycles(1);
    end
    for (int i = 0; i < 16; i++) begin
      idx = $urandom_range(0, 3);
      we  = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        gb_ram_cs = 1'b1;
        wait_cycles($urandom_range(1, 4));
        gb_ram_cs = 1'b0;
      end
      do_access(we, pool[idx], d, lat, rd, ok);
      n_total++;
      if (!ok || lat < LAT)
        $display("FAIL rand_access: iter %0d ok %0d latency %0d want >= %0d", i, ok, lat, LAT);
      else n_pass++;
      if (we) exp_mem[pool[idx]] = d;
      else begin
        n_total++;
        if (rd !== exp_mem[pool[idx]])
          $display("FAIL rand_read: iter %0d addr %h got %h want %h", i, pool[idx], rd,
                   exp_mem[pool[idx]]);
        else n_pass++;
      end
      wait_cycles($urandom_range(1, 3));
    end
  endtask

  task automatic test_reset_mid;
    int k, lat; logic [44:0] got; logic [7:0] rd; bit ok;
    wait_cycles(8);
    host_we = 1'b1; host_addr = 15'h7FFF; host_wdata = 8'hA5; host_req = 1'b1;
    k = 0;
    while (ram_we_n && k < 50) begin @(posedge clk); #1; k++; end
    #2;
    rst_n = 1'b0;
    #1;
    got = {ram_owner_gb, ram_ce_n, ram_we_n, ram_oe_n, ram_dq_oe, host_ack,
           host_rdata, ram_addr, ram_dq_out, abort_cnt};
    n_total++;
    if (k >= 50 || got !== {6'b111100, 39'd0})
      $display("FAIL reset_mid_strobe: got %h want %h", got, {6'b111100, 39'd0});
    else n_pass++;
    host_req = 1'b0;
    exp_aborts = 0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(8);
    n_total++;
    if (ram_ce_n !== 1'b1 || abort_cnt !== exp_abort_cnt())
      $display("FAIL reset_release: ce_n %b abort_cnt %0d want 1 and %0d", ram_ce_n, abort_cnt,
               exp_abort_cnt());
    else n_pass++;
    do_access(1'b0, pool[2], 8'h00, lat, rd, ok);
    n_total++;
    if (!ok || rd !== exp_mem[pool[2]] || lat !== LAT)
      $display("FAIL reset_recover: got %h lat %0d want %h lat %0d", rd, lat, exp_mem[pool[2]], LAT);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_write();
    test_read();
    test_guard();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    wait_cycles(2);
    n_total++;
    if (n_conflict !== 0) $display("FAIL bus_conflict: got %0d clocks want 0", n_conflict);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
